// File: rtl/icrc_strip.sv
// rtl/icrc_strip.sv - strips the 4-byte ICRC trailer from a 512-bit RoCE receive stream
// Optional statistics counters are built when ICRC_STRIP_STATS_EN is defined.
module icrc_strip #(
   parameter int DATA_BITS  = 512,
   parameter int ICRC_BYTES = 4
) (
   input  logic                     nclk,
   input  logic                     nreset,
   input  logic [DATA_BITS-1:0]     m_axis_rx_tdata,
   input  logic [DATA_BITS/8-1:0]   m_axis_rx_tkeep,
   input  logic                     m_axis_rx_tlast,
   input  logic                     m_axis_rx_tvalid,
   output logic                     m_axis_rx_tready,
   output logic [DATA_BITS-1:0]     m_axis_tx_tdata,
   output logic [DATA_BITS/8-1:0]   m_axis_tx_tkeep,
   output logic                     m_axis_tx_tlast,
   output logic                     m_axis_tx_tvalid,
   input  logic                     m_axis_tx_tready,
   output logic                     runt_drop,
   output logic [31:0]              pkt_cnt,
   output logic [15:0]              runt_cnt
);

   localparam int KEEP_W = DATA_BITS / 8;

   // HOLD stage: the most recent beat, kept back until we know whether it loses trailer bytes
   logic                 hold_valid_q, hold_valid_d;
   logic                 hold_final_q, hold_final_d;
   logic [DATA_BITS-1:0] hold_data_q,  hold_data_d;
   logic [KEEP_W-1:0]    hold_keep_q,  hold_keep_d;

   // OUT stage: the beat presented downstream
   logic                 out_valid_q,  out_valid_d;
   logic                 out_last_q,   out_last_d;
   logic [DATA_BITS-1:0] out_data_q,   out_data_d;
   logic [KEEP_W-1:0]    out_keep_q,   out_keep_d;

   logic                 runt_drop_q,  runt_drop_d;

   logic advance;
   logic accept;
   logic hold_open;
   logic keep_gt;
   logic keep_eq;

   // tkeep is contiguous from bit 0, so the byte count class is read from two keep bits
   assign keep_gt   = m_axis_rx_tkeep[ICRC_BYTES];
   assign keep_eq   = m_axis_rx_tkeep[ICRC_BYTES-1] && !m_axis_rx_tkeep[ICRC_BYTES];

   assign advance   = !out_valid_q || m_axis_tx_tready;
   assign accept    = advance && m_axis_rx_tvalid;
   // HOLD belongs to the packet still arriving (a final beat only waits to drain)
   assign hold_open = hold_valid_q && !hold_final_q;

   assign m_axis_rx_tready = advance;
   assign m_axis_tx_tdata  = out_data_q;
   assign m_axis_tx_tkeep  = out_keep_q;
   assign m_axis_tx_tlast  = out_last_q;
   assign m_axis_tx_tvalid = out_valid_q;
   assign runt_drop        = runt_drop_q;

   // next-state for HOLD/OUT: drain a final HOLD, then place the accepted beat
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_final_d = hold_final_q;
      hold_data_d  = hold_data_q;
      hold_keep_d  = hold_keep_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      runt_drop_d  = 1'b0;

      if (advance) begin
         out_valid_d = 1'b0;

         if (hold_valid_q && hold_final_q) begin
            out_valid_d  = 1'b1;
            out_last_d   = 1'b1;
            out_data_d   = hold_data_q;
            out_keep_d   = hold_keep_q;
            hold_valid_d = 1'b0;
         end

         if (accept) begin
            if (!m_axis_rx_tlast || keep_gt) begin
               if (hold_open) begin
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  out_data_d  = hold_data_q;
                  out_keep_d  = hold_keep_q;
               end
               hold_valid_d = 1'b1;
               hold_final_d = m_axis_rx_tlast;
               hold_data_d  = m_axis_rx_tdata;
               hold_keep_d  = m_axis_rx_tlast ? (m_axis_rx_tkeep >> ICRC_BYTES) : m_axis_rx_tkeep;
            end else if (hold_open) begin
               // trailer fits in this beat (k == 4) or spills back into the held beat (k < 4)
               out_valid_d  = 1'b1;
               out_last_d   = 1'b1;
               out_data_d   = hold_data_q;
               out_keep_d   = keep_eq ? hold_keep_q
                            : {m_axis_rx_tkeep[ICRC_BYTES-1:0], {(KEEP_W-ICRC_BYTES){1'b1}}};
               hold_valid_d = 1'b0;
            end else begin
               runt_drop_d  = 1'b1;
            end
         end
      end
   end

   // pipeline registers; reset discards any partial packet
   always_ff @(posedge nclk or posedge nreset) begin
      if (nreset) begin
         hold_valid_q <= 1'b0;
         hold_final_q <= 1'b0;
         hold_data_q  <= '0;
         hold_keep_q  <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         runt_drop_q  <= 1'b0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_final_q <= hold_final_d;
         hold_data_q  <= hold_data_d;
         hold_keep_q  <= hold_keep_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         runt_drop_q  <= runt_drop_d;
      end
   end

`ifdef ICRC_STRIP_STATS_EN
   logic [31:0] pkt_cnt_q;
   logic [15:0] runt_cnt_q;

   // wrapping packet and runt counters
   always_ff @(posedge nclk or posedge nreset) begin
      if (nreset) begin
         pkt_cnt_q  <= '0;
         runt_cnt_q <= '0;
      end else begin
         if (out_valid_q && m_axis_tx_tready && out_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (runt_drop_q) begin
            runt_cnt_q <= runt_cnt_q + 16'd1;
         end
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign runt_cnt = runt_cnt_q;
`else
   assign pkt_cnt  = '0;
   assign runt_cnt = '0;
`endif

endmodule

// File: tb/tb_icrc_strip.sv
// tb/tb_icrc_strip.sv - scoreboard bench for icrc_strip
module tb_icrc_strip;

   localparam logic [63:0] ONES = {64{1'b1}};

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] rx_tdata;
   logic [63:0]  rx_tkeep;
   logic         rx_tlast;
   logic         rx_tvalid;
   logic         rx_tready;
   logic [511:0] tx_tdata;
   logic [63:0]  tx_tkeep;
   logic         tx_tlast;
   logic         tx_tvalid;
   logic         tx_tready;
   logic         runt_drop;
   logic [31:0]  pkt_cnt;
   logic [15:0]  runt_cnt;

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    runt_exp = 0;
   int    runt_seen = 0;
   bit    toggle_en = 1'b0;

   always #5 clk = ~clk;

   icrc_strip dut (
      .nclk             (clk),
      .nreset           (rst),
      .m_axis_rx_tdata  (rx_tdata),
      .m_axis_rx_tkeep  (rx_tkeep),
      .m_axis_rx_tlast  (rx_tlast),
      .m_axis_rx_tvalid (rx_tvalid),
      .m_axis_rx_tready (rx_tready),
      .m_axis_tx_tdata  (tx_tdata),
      .m_axis_tx_tkeep  (tx_tkeep),
      .m_axis_tx_tlast  (tx_tlast),
      .m_axis_tx_tvalid (tx_tvalid),
      .m_axis_tx_tready (tx_tready),
      .runt_drop        (runt_drop),
      .pkt_cnt          (pkt_cnt),
      .runt_cnt         (runt_cnt)
   );

   function automatic logic [511:0] pat(input logic [31:0] n);
      return {16{n}};
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
      beat_t b;
      b.d = d;
      b.k = k;
      b.l = l;
      exp_q.push_back(b);
   endtask

   task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
      bit hs;
      int cyc;
      @(negedge clk);
      rx_tdata  = d;
      rx_tkeep  = k;
      rx_tlast  = l;
      rx_tvalid = 1'b1;
      cyc = 0;
      forever begin
         #1;
         hs = rx_tready;
         @(posedge clk);
         if (hs) break;
         cyc++;
         if (cyc > 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_handshake required=handshake");
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d required=0 beats pending", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst       = 1'b1;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // tready toggler for the stall test
   initial begin
      forever begin
         @(negedge clk);
         if (toggle_en) tx_tready = ~tx_tready;
      end
   end

   // monitor: pops the scoreboard on each output handshake and checks stall stability
   initial begin
      beat_t e;
      beat_t prev;
      bit prev_stall;
      bit prev_runt;
      prev_stall = 1'b0;
      prev_runt  = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
            prev_runt  = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 512'(tx_tvalid), 512'(1'b1));
               chk("stall_data", tx_tdata, prev.d);
               chk("stall_keep", 512'(tx_tkeep), 512'(prev.k));
               chk("stall_last", 512'(tx_tlast), 512'(prev.l));
            end
            if (tx_tvalid && tx_tready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat actual=keep_%h required=no_beat", tx_tkeep);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", tx_tdata, e.d);
                  chk("beat_keep", 512'(tx_tkeep), 512'(e.k));
                  chk("beat_last", 512'(tx_tlast), 512'(e.l));
               end
            end
            if (runt_drop) begin
               runt_seen++;
               chk("runt_single_cycle", 512'(prev_runt), 512'(1'b0));
            end
            prev_runt  = runt_drop;
            prev_stall = tx_tvalid && !tx_tready;
            prev.d     = tx_tdata;
            prev.k     = tx_tkeep;
            prev.l     = tx_tlast;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pkt;
      int exp_runt;

      rst       = 1'b1;
      rx_tdata  = '0;
      rx_tkeep  = '0;
      rx_tlast  = 1'b0;
      rx_tvalid = 1'b0;
      tx_tready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", 512'(tx_tvalid), 512'(1'b0));
      chk("rst_tlast", 512'(tx_tlast), 512'(1'b0));
      chk("rst_tkeep", 512'(tx_tkeep), 512'(64'h0));
      chk("rst_tdata", tx_tdata, 512'h0);
      chk("rst_rx_tready", 512'(rx_tready), 512'(1'b1));
      chk("rst_runt_drop", 512'(runt_drop), 512'(1'b0));
      chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(32'h0));
      chk("rst_runt_cnt", 512'(runt_cnt), 512'(16'h0));
      @(negedge clk);
      rst       = 1'b0;
      tx_tready = 1'b1;
      #1;
      chk("idle_rx_tready", 512'(rx_tready), 512'(1'b1));

      // 3-beat packet, 40 B last beat -> last keeps 36 B
      expect_beat(pat(32'hA1000001), ONES, 1'b0);
      expect_beat(pat(32'hA1000002), ONES, 1'b0);
      expect_beat(pat(32'hA1000003), 64'h0000000fffffffff, 1'b1);
      send(pat(32'hA1000001), ONES, 1'b0);
      send(pat(32'hA1000002), ONES, 1'b0);
      send(pat(32'hA1000003), 64'h000000ffffffffff, 1'b1);

      // 2-beat packet, last beat is exactly the ICRC
      expect_beat(pat(32'hB2000001), ONES, 1'b1);
      send(pat(32'hB2000001), ONES, 1'b0);
      send(pat(32'hB2000002), 64'h000000000000000f, 1'b1);

      // 2-beat packet, ICRC spans the boundary: previous beat loses 2 B
      expect_beat(pat(32'hC3000001), 64'h3fffffffffffffff, 1'b1);
      send(pat(32'hC3000001), ONES, 1'b0);
      send(pat(32'hC3000002), 64'h0000000000000003, 1'b1);

      // runt: single 3-byte beat
      runt_exp++;
      send(pat(32'hD4000001), 64'h0000000000000007, 1'b1);
      idle();
      drain();

      chk("runt_pulses", 512'(runt_seen), 512'(runt_exp));
`ifdef ICRC_STRIP_STATS_EN
      exp_pkt  = 3;
      exp_runt = 1;
`else
      exp_pkt  = 0;
      exp_runt = 0;
`endif
      chk("pkt_cnt_a", 512'(pkt_cnt), 512'(exp_pkt));
      chk("runt_cnt_a", 512'(runt_cnt), 512'(exp_runt));

      // back-to-back 2-beat packets with tready toggling
      pulse_reset();
      toggle_en = 1'b1;
      expect_beat(pat(32'hE5000001), ONES, 1'b0);
      expect_beat(pat(32'hE5000002), 64'h0fffffffffffffff, 1'b1);
      expect_beat(pat(32'hE6000001), ONES, 1'b0);
      expect_beat(pat(32'hE6000002), 64'h0fffffffffffffff, 1'b1);
      send(pat(32'hE5000001), ONES, 1'b0);
      send(pat(32'hE5000002), ONES, 1'b1);
      send(pat(32'hE6000001), ONES, 1'b0);
      send(pat(32'hE6000002), ONES, 1'b1);
      idle();
      drain();
      toggle_en = 1'b0;
      @(negedge clk);
      tx_tready = 1'b1;
      repeat (2) @(negedge clk);
`ifdef ICRC_STRIP_STATS_EN
      exp_pkt = 2;
`else
      exp_pkt = 0;
`endif
      chk("pkt_cnt_b2b", 512'(pkt_cnt), 512'(exp_pkt));

      // reset mid-packet, then a fresh packet with a 16 B last beat
      send(pat(32'hF7000001), ONES, 1'b0);
      idle();
      pulse_reset();
      expect_beat(pat(32'hF8000001), ONES, 1'b0);
      expect_beat(pat(32'hF8000002), 64'h0000000000000fff, 1'b1);
      send(pat(32'hF8000001), ONES, 1'b0);
      send(pat(32'hF8000002), 64'h000000000000ffff, 1'b1);
      idle();
      drain();
`ifdef ICRC_STRIP_STATS_EN
      exp_pkt = 1;
`else
      exp_pkt = 0;
`endif
      chk("pkt_cnt_after_reset", 512'(pkt_cnt), 512'(exp_pkt));
      chk("final_tvalid", 512'(tx_tvalid), 512'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
